// File: rtl/hex_display_scanner.sv
// Time-shared seven-segment scanner: decodes one nibble per clock into a shadow
// buffer, then commits all digits at once. Optional blink gating under HEX_BLINK_EN.
module hex_display_scanner #(
   parameter int NUM_DIGITS = 6,
   parameter int BLINK_DIV  = 25000000
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [4*NUM_DIGITS-1:0]   value_in,
   input  logic                      blank_lz,
   input  logic                      load_valid,
`ifdef HEX_BLINK_EN
   input  logic                      blink,
`endif
   output logic                      load_ready,
   output logic                      busy,
   output logic                      done,
   output logic [7*NUM_DIGITS-1:0]   hex_out
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV,
      S_COMMIT
   } state_t;

   state_t                    state_q, state_d;
   logic [4*NUM_DIGITS-1:0]   value_q, value_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic                      lz_q, lz_d;
   logic [7*NUM_DIGITS-1:0]   shadow_q, shadow_d;
   logic [7*NUM_DIGITS-1:0]   hex_q, hex_d;
   logic                      done_q, done_d;
   logic                      busy_q, busy_d;
   logic [3:0]                nibble;

   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      logic [6:0] seg;
      case (n)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h18;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every combinational output gets a default first, so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (load_valid) state_d = S_CONV;
         S_CONV:   if (idx_q == '0) state_d = S_COMMIT;
         S_COMMIT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      value_d  = value_q;
      lz_d     = lz_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      hex_d    = hex_q;
      done_d   = 1'b0;
      busy_d   = (state_d != S_IDLE);
      nibble   = value_q[4*idx_q +: 4];
      case (state_q)
         S_IDLE: begin
            if (load_valid) begin
               value_d = value_in;
               lz_d    = blank_lz;
               idx_d   = IDX_W'(NUM_DIGITS - 1);
            end
         end
         S_CONV: begin
            // Digit 0 is always decoded so a zero value still shows "0".
            if (lz_q && (nibble == 4'h0) && (idx_q != '0)) begin
               shadow_d[7*idx_q +: 7] = 7'h7f;
            end else begin
               shadow_d[7*idx_q +: 7] = seg_decode(nibble);
               lz_d                   = 1'b0;
            end
            idx_d = idx_q - IDX_W'(1);
         end
         S_COMMIT: begin
            hex_d  = shadow_q;
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   // NOTE: the shadow buffer is reset like any other register; it is small and
   // its blank reset value is part of the block's defined state.
   always_ff @(posedge clock) begin
      if (reset) begin
         value_q  <= '0;
         lz_q     <= 1'b0;
         idx_q    <= '0;
         shadow_q <= '1;
         hex_q    <= '1;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         value_q  <= value_d;
         lz_q     <= lz_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         hex_q    <= hex_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

`ifdef HEX_BLINK_EN
   localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;

   always_comb begin
      cnt_d   = cnt_q + CNT_W'(1);
      phase_d = phase_q;
      if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end
`endif

   always_comb begin
      load_ready = ~busy_q;
      busy       = busy_q;
      done       = done_q;
`ifdef HEX_BLINK_EN
      hex_out    = (blink && phase_q) ? '1 : hex_q;
`else
      hex_out    = hex_q;
`endif
   end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed self-checking bench for hex_display_scanner (default build, six digits).
module tb_hex_display_scanner;

   localparam int N = 6;

   logic           clock;
   logic           reset;
   logic [4*N-1:0] value_in;
   logic           blank_lz;
   logic           load_valid;
   logic           load_ready;
   logic           busy;
   logic           done;
   logic [7*N-1:0] hex_out;

   int checks = 0;
   int errors = 0;

   localparam logic [41:0] BLANK  = {42{1'b1}};
   localparam logic [41:0] EXP_A  = {7'h79, 7'h24, 7'h08, 7'h03, 7'h30, 7'h0E}; // 12AB3F
   localparam logic [41:0] EXP_B  = {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h12, 7'h40}; // 000450 lz
   localparam logic [41:0] EXP_Z  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}; // 000000 lz
   localparam logic [41:0] EXP_F  = {6{7'h0E}};                                  // FFFFFF
   localparam logic [41:0] EXP_O  = {7'h79, 7'h30, 7'h12, 7'h78, 7'h18, 7'h03}; // 13579B
   localparam logic [41:0] EXP_E  = {7'h24, 7'h19, 7'h02, 7'h00, 7'h08, 7'h46}; // 2468AC
   localparam logic [41:0] EXP_R  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40}; // 0000A0 lz

   hex_display_scanner #(.NUM_DIGITS(N)) dut (
      .clock      (clock),
      .reset      (reset),
      .value_in   (value_in),
      .blank_lz   (blank_lz),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .busy       (busy),
      .done       (done),
      .hex_out    (hex_out)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Offers a value for one edge, then checks the full conversion timeline.
   task automatic do_load(input string tag, input logic [23:0] v, input logic lz,
                          input logic [41:0] exp, input logic [41:0] prev);
      value_in   = v;
      blank_lz   = lz;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      check({tag, " accept busy"}, 64'(busy), 64'(1));
      for (int k = 1; k <= N; k++) begin
         tick();
         check({tag, " conv ready"}, 64'(load_ready), 64'(0));
         check({tag, " conv done"}, 64'(done), 64'(0));
         check({tag, " conv hold"}, 64'(hex_out), 64'(prev));
      end
      tick();
      check({tag, " done"}, 64'(done), 64'(1));
      check({tag, " hex"}, 64'(hex_out), 64'(exp));
      check({tag, " ready"}, 64'(load_ready), 64'(1));
      check({tag, " busy"}, 64'(busy), 64'(0));
   endtask

   initial begin
      reset      = 1'b1;
      load_valid = 1'b0;
      value_in   = '0;
      blank_lz   = 1'b0;
      tick();
      tick();
      check("rst hex", 64'(hex_out), 64'(BLANK));
      check("rst ready", 64'(load_ready), 64'(1));
      check("rst busy", 64'(busy), 64'(0));
      check("rst done", 64'(done), 64'(0));
      reset = 1'b0;
      tick();

      do_load("12AB3F", 24'h12AB3F, 1'b0, EXP_A, BLANK);
      tick();
      check("12AB3F done drop", 64'(done), 64'(0));
      check("12AB3F idle hold", 64'(hex_out), 64'(EXP_A));

      do_load("000450", 24'h000450, 1'b1, EXP_B, EXP_A);
      tick();

      do_load("000000", 24'h000000, 1'b1, EXP_Z, EXP_B);
      // Offer the next value while done is high; it must be taken on the next edge.
      do_load("FFFFFF", 24'hFFFFFF, 1'b0, EXP_F, EXP_Z);
      tick();

      // A held request during conversion must wait for load_ready.
      value_in   = 24'h13579B;
      blank_lz   = 1'b0;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      tick();
      value_in   = 24'h2468AC;
      blank_lz   = 1'b1;
      load_valid = 1'b1;
      for (int k = 2; k <= N; k++) begin
         check("held ready low", 64'(load_ready), 64'(0));
         tick();
      end
      tick();
      check("held first done", 64'(done), 64'(1));
      check("held first hex", 64'(hex_out), 64'(EXP_O));
      tick();
      load_valid = 1'b0;
      check("held second accept", 64'(busy), 64'(1));
      check("held second done low", 64'(done), 64'(0));
      for (int k = 1; k <= N; k++) begin
         tick();
         check("held second hold", 64'(hex_out), 64'(EXP_O));
      end
      tick();
      check("held second done", 64'(done), 64'(1));
      check("held second hex", 64'(hex_out), 64'(EXP_E));
      tick();

      // Reset at T0+3 discards the conversion.
      value_in   = 24'h777777;
      blank_lz   = 1'b0;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst hex", 64'(hex_out), 64'(BLANK));
      check("midrst busy", 64'(busy), 64'(0));
      check("midrst ready", 64'(load_ready), 64'(1));
      check("midrst done", 64'(done), 64'(0));
      for (int k = 0; k < 2 * N; k++) begin
         tick();
         check("midrst no done", 64'(done), 64'(0));
      end
      check("midrst hex after", 64'(hex_out), 64'(BLANK));

      do_load("0000A0", 24'h0000A0, 1'b1, EXP_R, BLANK);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
